// File: rtl/neuron_pkg.sv
// Shared types and arithmetic for the neuron accumulator datapath.
// sat_add works on a 32-bit carrier so one function serves any accumulator width up to 31 bits.
package neuron_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ACC_W_DEF  = 16;
  localparam int SUM_W      = 32;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    OUTPUT
  } nacc_state_t;

  typedef struct packed {
    logic signed [SUM_W-1:0] sum;
    logic                    ovf;
  } sat_add_t;

  // Operands must already lie within the acc_w signed range, so a 32-bit add cannot wrap.
  function automatic sat_add_t sat_add(input logic signed [SUM_W-1:0] a,
                                       input logic signed [SUM_W-1:0] b,
                                       input int                      acc_w);
    sat_add_t                res;
    int                      hi;
    int                      lo;
    logic signed [SUM_W-1:0] s;
    hi      = (1 << (acc_w - 1)) - 1;
    lo      = -hi - 1;
    s       = a + b;
    res.sum = s;
    res.ovf = 1'b0;
    if (s > hi) begin
      res.sum = hi;
      res.ovf = 1'b1;
    end else if (s < lo) begin
      res.sum = lo;
      res.ovf = 1'b1;
    end
    return res;
  endfunction

endpackage

// File: rtl/neuron_sat.sv
// Narrows the wide accumulator to the activation width with optional ReLU.
// sat_out flags only a clamp at this stage; ReLU zeroing is not counted as saturation.
module neuron_sat
  import neuron_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ACC_W   = ACC_W_DEF,
  parameter int RELU_EN = 1
) (
  input  logic signed [ACC_W-1:0]  acc_in,
  output logic        [DATA_W-1:0] data_out,
  output logic                     sat_out
);

  localparam logic signed [ACC_W-1:0] D_MAX = ACC_W'((1 << (DATA_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] D_MIN = ACC_W'(-(1 << (DATA_W - 1)));

  always_comb begin
    data_out = acc_in[DATA_W-1:0];
    sat_out  = 1'b0;
    if ((RELU_EN != 0) && acc_in[ACC_W-1]) begin
      data_out = '0;
    end else if (acc_in > D_MAX) begin
      data_out = D_MAX[DATA_W-1:0];
      sat_out  = 1'b1;
    end else if (acc_in < D_MIN) begin
      data_out = D_MIN[DATA_W-1:0];
      sat_out  = 1'b1;
    end
  end

endmodule

// File: rtl/neuron_accumulator.sv
// Streams signed terms into a bias-seeded saturating accumulator and hands the
// narrowed activation downstream over a valid/ready handshake.
//
// state  | meaning
// IDLE   | no term taken yet this frame
// ACCUM  | at least one term taken, last not yet seen
// OUTPUT | holding the result until downstream takes it
module neuron_accumulator
  import neuron_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ACC_W   = ACC_W_DEF,
  parameter int BIAS    = 0,
  parameter int RELU_EN = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_sat
);

  localparam logic signed [ACC_W-1:0] BIAS_EXT = ACC_W'(BIAS);

  nacc_state_t              state_q, state_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic                     sat_q, sat_d;
  logic                     out_valid_q, out_valid_d;
  logic        [DATA_W-1:0] out_data_q, out_data_d;
  logic                     out_sat_q, out_sat_d;

  sat_add_t                 add_res;
  logic signed [ACC_W-1:0]  acc_sum;
  logic                     sat_sum;
  logic        [DATA_W-1:0] res_data;
  logic                     res_clamp;
  logic                     accept;
  logic                     unused_sum_hi;

  assign in_ready  = (state_q != OUTPUT);
  assign accept    = in_valid & in_ready;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;

  assign add_res       = sat_add(SUM_W'(acc_q), SUM_W'($signed(in_data)), ACC_W);
  assign acc_sum       = add_res.sum[ACC_W-1:0];
  assign sat_sum       = sat_q | add_res.ovf;
  assign unused_sum_hi = ^add_res.sum[SUM_W-1:ACC_W];

  // Narrowing sees the post-add value so the final term is included in the result.
  neuron_sat #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W),
    .RELU_EN(RELU_EN)
  ) u_sat (
    .acc_in  (acc_sum),
    .data_out(res_data),
    .sat_out (res_clamp)
  );

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    sat_d       = sat_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sat_d   = out_sat_q;
    unique case (state_q)
      IDLE, ACCUM: begin
        if (accept) begin
          acc_d = acc_sum;
          sat_d = sat_sum;
          if (in_last) begin
            state_d     = OUTPUT;
            out_valid_d = 1'b1;
            out_data_d  = res_data;
            out_sat_d   = sat_sum | res_clamp;
          end else begin
            state_d = ACCUM;
          end
        end
      end
      OUTPUT: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          acc_d       = BIAS_EXT;
          sat_d       = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= BIAS_EXT;
      sat_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      sat_q       <= sat_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sat_q   <= out_sat_d;
    end
  end

endmodule
